// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared states, funct3 codes and error causes for the load/store unit
package load_store_unit_pkg;
  typedef enum logic [1:0] {
    LSU_STATE__IDLE,
    LSU_STATE__WAIT,
    LSU_STATE__RESP
  } lsu_state_t;
  typedef enum logic [1:0] {
    LSU_ERR__NONE,
    LSU_ERR__MISALIGNED,
    LSU_ERR__ILLEGAL,
    LSU_ERR__TIMEOUT
  } lsu_err_t;
  localparam logic [2:0] LSU_F3__LB  = 3'b000;
  localparam logic [2:0] LSU_F3__LH  = 3'b001;
  localparam logic [2:0] LSU_F3__LW  = 3'b010;
  localparam logic [2:0] LSU_F3__LBU = 3'b100;
  localparam logic [2:0] LSU_F3__LHU = 3'b101;
  localparam logic [2:0] LSU_F3__SB  = 3'b000;
  localparam logic [2:0] LSU_F3__SH  = 3'b001;
  localparam logic [2:0] LSU_F3__SW  = 3'b010;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte enables, lane-replicated store data, extended load data and access checks
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        illegal
);
  logic [1:0]  size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  always_comb begin
    size = funct3[1:0];
    illegal = we ? !(funct3 inside {LSU_F3__SB, LSU_F3__SH, LSU_F3__SW})
                 : !(funct3 inside {LSU_F3__LB, LSU_F3__LH, LSU_F3__LW, LSU_F3__LBU, LSU_F3__LHU});
    misaligned = size == 2'd1 ? addr[0] : size == 2'd2 ? |addr : 1'b0;
    be = size == 2'd0 ? 4'b0001 << addr : size == 2'd1 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    store_data = !we ? 32'd0 : size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
    byte_sel = mem_rdata[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // funct3[2] marks the unsigned load variants
    load_data = size == 2'd0 ? {{24{~funct3[2] & byte_sel[7]}}, byte_sel}
              : size == 2'd1 ? {{16{~funct3[2] & half_sel[15]}}, half_sel} : mem_rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: req/ack load/store engine with fault detection; LSU_TIMEOUT_EN adds a WAIT timeout
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        error,
  output logic [1:0]  error_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  lsu_state_t  state, state_n;
  lsu_err_t    cause, cause_n;
  logic        busy_n, done_n, error_n, mem_req_n, mem_we_n, timeout;
  logic [31:0] mem_addr_n, mem_wdata_n, rdata_n;
  logic [3:0]  mem_be_n;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [3:0]  be;
  logic [31:0] st_data, ld_data;
  logic        misaligned, illegal;
  // the aligner sees live inputs when accepting and the captured access while waiting
  lsu_lane_align u_align (
    .we        (state == LSU_STATE__IDLE ? we : mem_we),
    .funct3    (state == LSU_STATE__IDLE ? funct3 : f3_q),
    .addr      (state == LSU_STATE__IDLE ? addr[1:0] : lo_q),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .be        (be),
    .store_data(st_data),
    .load_data (ld_data),
    .misaligned(misaligned),
    .illegal   (illegal)
  );
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= state == LSU_STATE__WAIT ? cnt + 1'b1 : '0;
  assign timeout = state == LSU_STATE__WAIT && !mem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    busy_n = busy;
    done_n = 1'b0;
    error_n = error;
    cause_n = cause;
    mem_req_n = mem_req;
    mem_we_n = mem_we;
    mem_addr_n = mem_addr;
    mem_be_n = mem_be;
    mem_wdata_n = mem_wdata;
    rdata_n = rdata;
    case (state)
      LSU_STATE__IDLE: if (req) begin
        busy_n = 1'b1;
        if (illegal || misaligned) begin
          state_n = LSU_STATE__RESP;
          done_n = 1'b1;
          error_n = 1'b1;
          cause_n = illegal ? LSU_ERR__ILLEGAL : LSU_ERR__MISALIGNED;
        end else begin
          state_n = LSU_STATE__WAIT;
          error_n = 1'b0;
          cause_n = LSU_ERR__NONE;
          mem_req_n = 1'b1;
          mem_we_n = we;
          mem_addr_n = {addr[31:2], 2'b00};
          mem_be_n = be;
          mem_wdata_n = st_data;
        end
      end
      LSU_STATE__WAIT: if (mem_ack || timeout) begin
        state_n = LSU_STATE__RESP;
        done_n = 1'b1;
        mem_req_n = 1'b0;
        error_n = !mem_ack;
        cause_n = mem_ack ? LSU_ERR__NONE : LSU_ERR__TIMEOUT;
        rdata_n = mem_ack && !mem_we ? ld_data : rdata;
      end
      LSU_STATE__RESP: begin
        state_n = LSU_STATE__IDLE;
        busy_n = 1'b0;
      end
      default: state_n = LSU_STATE__IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= LSU_STATE__IDLE;
      cause <= LSU_ERR__NONE;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      f3_q <= '0;
      lo_q <= '0;
    end else begin
      state <= state_n;
      cause <= cause_n;
      busy <= busy_n;
      done <= done_n;
      error <= error_n;
      mem_req <= mem_req_n;
      mem_we <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_be <= mem_be_n;
      mem_wdata <= mem_wdata_n;
      rdata <= rdata_n;
      if (state == LSU_STATE__IDLE && req) begin
        f3_q <= funct3;
        lo_q <= addr[1:0];
      end
    end
  assign error_cause = cause;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors with a scoreboard checking every done response
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  logic clk = 0, reset = 1, req = 0, we = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic busy, done, error, mem_req, mem_we;
  logic [1:0] error_cause;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  always #5 clk = ~clk;
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .error(error), .error_cause(error_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  typedef struct packed {
    logic        err;
    logic [1:0]  cause;
    logic [31:0] rdata;
  } resp_t;
  resp_t exp_q[$];
  resp_t got;
  int n_checks = 0, n_fails = 0;
  logic [31:0] last_rdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL spurious_done: done=1 with no access outstanding");
      end else begin
        got = exp_q.pop_front();
        chk("resp_error", {31'd0, error}, {31'd0, got.err});
        chk("resp_cause", {30'd0, error_cause}, {30'd0, got.cause});
        chk("resp_rdata", rdata, got.rdata);
      end
    end

  // called right after a negedge with the unit idle; returns at a negedge with the unit idle again
  task automatic access(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] md, input int lat, input bit to,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [1:0] ecause,
                        input logic [31:0] erd, input bit poke);
    bit fault;
    fault = ecause == 2'b01 || ecause == 2'b10;
    if (!w && ecause == 2'b00) last_rdata = erd;
    exp_q.push_back({ecause != 2'b00, ecause, last_rdata});
    req = 1; we = w; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 0; we = ~w; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h1357_9BDF;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    if (fault) begin
      chk({nm, "_noreq"}, {31'd0, mem_req}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd1);
    end else begin
      for (int c = 1; c <= lat; c++) begin
        chk({nm, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({nm, "_we"}, {31'd0, mem_we}, {31'd0, w});
        chk({nm, "_addr"}, mem_addr, {a[31:2], 2'b00});
        chk({nm, "_be"}, {28'd0, mem_be}, {28'd0, ebe});
        chk({nm, "_wdata"}, mem_wdata, ewd);
        chk({nm, "_nodone"}, {31'd0, done}, 32'd0);
        mem_ack = !to && c == lat;
        mem_rdata = mem_ack ? md : 32'h5A5A_0000 ^ c;
        @(negedge clk);
      end
      mem_ack = 0;
      chk({nm, "_reqdrop"}, {31'd0, mem_req}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd1);
    end
    if (poke) begin
      req = 1; we = 1; funct3 = LSU_F3__SW; addr = 32'h300; wdata = 32'h0BAD_0BAD;
    end
    @(negedge clk);
    req = 0;
    chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_donegone"}, {31'd0, done}, 32'd0);
    if (poke) begin
      @(negedge clk);
      chk({nm, "_respreq_ignored"}, {31'd0, mem_req | busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {29'd0, error, error_cause}, 32'd0);
    chk("rst_memreq", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    chk("rst_membe", {28'd0, mem_be}, 32'd0);
    chk("rst_memwdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    access("sw",  1, LSU_F3__SW,  32'h100, 32'hDEADBEEF, 32'h0, 3, 0, 4'b1111, 32'hDEADBEEF, 2'b00, 32'h0, 0);
    access("lb",  0, LSU_F3__LB,  32'h103, 32'h0, 32'h80FF1234, 1, 0, 4'b1000, 32'h0, 2'b00, 32'hFFFFFF80, 0);
    access("lbu", 0, LSU_F3__LBU, 32'h103, 32'h0, 32'h80FF1234, 2, 0, 4'b1000, 32'h0, 2'b00, 32'h00000080, 0);
    access("lhu", 0, LSU_F3__LHU, 32'h102, 32'h0, 32'h80FF1234, 1, 0, 4'b1100, 32'h0, 2'b00, 32'h000080FF, 0);
    access("lh",  0, LSU_F3__LH,  32'h100, 32'h0, 32'h80FF8234, 1, 0, 4'b0011, 32'h0, 2'b00, 32'hFFFF8234, 0);
    access("lw",  0, LSU_F3__LW,  32'h104, 32'h0, 32'h12345678, 2, 0, 4'b1111, 32'h0, 2'b00, 32'h12345678, 0);
    access("sh",  1, LSU_F3__SH,  32'h202, 32'h0000ABCD, 32'h0, 1, 0, 4'b1100, 32'hABCDABCD, 2'b00, 32'h0, 0);
    access("sb",  1, LSU_F3__SB,  32'h101, 32'h0000005A, 32'h0, 2, 0, 4'b0010, 32'h5A5A5A5A, 2'b00, 32'h0, 0);
    access("lw_mis", 0, LSU_F3__LW, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0, 32'h0, 2'b01, 32'h0, 1);
    access("ill_ld", 0, 3'b011, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0, 32'h0, 2'b10, 32'h0, 0);
    access("ill_st", 1, 3'b100, 32'h0, 32'h0, 32'h0, 0, 0, 4'b0, 32'h0, 2'b10, 32'h0, 0);
    access("sh_mis", 1, LSU_F3__SH, 32'h201, 32'h0, 32'h0, 0, 0, 4'b0, 32'h0, 2'b01, 32'h0, 0);
    req = 1; we = 0; funct3 = LSU_F3__LW; addr = 32'h40;
    @(negedge clk);
    req = 0;
    chk("rstmid_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rstmid_reqdrop", {31'd0, mem_req}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    last_rdata = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("rstmid_nodone_pending", exp_q.size(), 32'd0);
    access("sw0", 1, LSU_F3__SW, 32'h0, 32'h11223344, 32'h0, 1, 0, 4'b1111, 32'h11223344, 2'b00, 32'h0, 0);
`ifdef LSU_TIMEOUT_EN
    access("tmo",    0, LSU_F3__LW, 32'h8, 32'h0, 32'h0, 4, 1, 4'b1111, 32'h0, 2'b11, 32'h0, 0);
    access("ack_c4", 0, LSU_F3__LW, 32'h8, 32'h0, 32'hAABBCCDD, 4, 0, 4'b1111, 32'h0, 2'b00, 32'hAABBCCDD, 0);
`endif
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
